// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles every handshake/bus signal between mem_arbiter, its two
//   clients and the MemDPI memory port.
//   slave  : arbiter side (client requests/write beats and memory read
//            beats in; grants, routed beats, busy/owner out)
//   master : environment side (clients + MemDPI), directions reversed
//   Signals:
//     cN_req_valid/opcode/len/addr, cN_req_ready   request handshake, N=0,1
//     cN_wr_valid/bits                              write beats from client N
//     cN_rd_valid/bits, cN_rd_ready                 read beats to client N
//     mem_req_valid/opcode/len/addr                 request to MemDPI
//     mem_wr_valid/bits                             write beat to MemDPI
//     mem_rd_valid/bits, mem_rd_ready               read beat from MemDPI
//     busy, owner                                   arbiter status
interface mem_arbiter_if #(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 32,
  parameter int MEM_DATA_BITS = 64
);
  logic                     c0_req_valid;
  logic                     c0_req_ready;
  logic                     c0_req_opcode;
  logic [MEM_LEN_BITS-1:0]  c0_req_len;
  logic [MEM_ADDR_BITS-1:0] c0_req_addr;
  logic                     c0_wr_valid;
  logic [MEM_DATA_BITS-1:0] c0_wr_bits;
  logic                     c0_rd_valid;
  logic [MEM_DATA_BITS-1:0] c0_rd_bits;
  logic                     c0_rd_ready;

  logic                     c1_req_valid;
  logic                     c1_req_ready;
  logic                     c1_req_opcode;
  logic [MEM_LEN_BITS-1:0]  c1_req_len;
  logic [MEM_ADDR_BITS-1:0] c1_req_addr;
  logic                     c1_wr_valid;
  logic [MEM_DATA_BITS-1:0] c1_wr_bits;
  logic                     c1_rd_valid;
  logic [MEM_DATA_BITS-1:0] c1_rd_bits;
  logic                     c1_rd_ready;

  logic                     mem_req_valid;
  logic                     mem_req_opcode;
  logic [MEM_LEN_BITS-1:0]  mem_req_len;
  logic [MEM_ADDR_BITS-1:0] mem_req_addr;
  logic                     mem_wr_valid;
  logic [MEM_DATA_BITS-1:0] mem_wr_bits;
  logic                     mem_rd_valid;
  logic [MEM_DATA_BITS-1:0] mem_rd_bits;
  logic                     mem_rd_ready;

  logic                     busy;
  logic                     owner;

  modport slave (
    input  c0_req_valid, c0_req_opcode, c0_req_len, c0_req_addr,
    input  c0_wr_valid, c0_wr_bits, c0_rd_ready,
    input  c1_req_valid, c1_req_opcode, c1_req_len, c1_req_addr,
    input  c1_wr_valid, c1_wr_bits, c1_rd_ready,
    input  mem_rd_valid, mem_rd_bits,
    output c0_req_ready, c0_rd_valid, c0_rd_bits,
    output c1_req_ready, c1_rd_valid, c1_rd_bits,
    output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    output mem_wr_valid, mem_wr_bits, mem_rd_ready,
    output busy, owner
  );

  modport master (
    output c0_req_valid, c0_req_opcode, c0_req_len, c0_req_addr,
    output c0_wr_valid, c0_wr_bits, c0_rd_ready,
    output c1_req_valid, c1_req_opcode, c1_req_len, c1_req_addr,
    output c1_wr_valid, c1_wr_bits, c1_rd_ready,
    output mem_rd_valid, mem_rd_bits,
    input  c0_req_ready, c0_rd_valid, c0_rd_bits,
    input  c1_req_ready, c1_rd_valid, c1_rd_bits,
    input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    input  mem_wr_valid, mem_wr_bits, mem_rd_ready,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one MemDPI memory port between two clients. Whole transactions
//   (request plus len+1 data beats) are granted round-robin; during the
//   transaction data beats are routed only to/from the owning client.
//   Ports:
//     clock  in  single clock
//     reset  in  synchronous, active-high
//     bus    mem_arbiter_if.slave (client, memory and status signals)
module mem_arbiter #(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 32,
  parameter int MEM_DATA_BITS = 64
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_owner, w_owner_nxt;
  logic                     r_prio,  w_prio_nxt;
  logic [MEM_LEN_BITS-1:0]  r_beats, w_beats_nxt;

  logic                     w_grant;
  logic                     w_gnt_sel;
  logic                     w_gnt_op;
  logic [MEM_LEN_BITS-1:0]  w_gnt_len;
  logic [MEM_ADDR_BITS-1:0] w_gnt_addr;
  logic                     w_own_rd_ready;
  logic                     w_own_wr_valid;
  logic                     w_beat;

  // Tie goes to r_prio; otherwise the lone requester. A grant is never
  // issued while reset is asserted.
  assign w_gnt_sel  = (bus.c0_req_valid && bus.c1_req_valid) ? r_prio : bus.c1_req_valid;
  assign w_grant    = (r_state == IDLE) && !reset && (bus.c0_req_valid || bus.c1_req_valid);
  assign w_gnt_op   = w_gnt_sel ? bus.c1_req_opcode : bus.c0_req_opcode;
  assign w_gnt_len  = w_gnt_sel ? bus.c1_req_len    : bus.c0_req_len;
  assign w_gnt_addr = w_gnt_sel ? bus.c1_req_addr   : bus.c0_req_addr;

  assign w_own_rd_ready = r_owner ? bus.c1_rd_ready : bus.c0_rd_ready;
  assign w_own_wr_valid = r_owner ? bus.c1_wr_valid : bus.c0_wr_valid;

  // Write beats have no backpressure: every owner wr_valid cycle counts.
  assign w_beat = ((r_state == READ)  && bus.mem_rd_valid && w_own_rd_ready) ||
                  ((r_state == WRITE) && w_own_wr_valid);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_beats <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_prio  <= w_prio_nxt;
      r_beats <= w_beats_nxt;
    end
  end

  // Next-state logic; r_beats holds the beats remaining minus one, so a
  // beat seen with r_beats == 0 is the last one (len = max gives max+1 beats).
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_prio_nxt  = r_prio;
    w_beats_nxt = r_beats;
    unique case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_owner_nxt = w_gnt_sel;
          w_prio_nxt  = ~w_gnt_sel;
          w_beats_nxt = w_gnt_len;
          w_state_nxt = w_gnt_op ? WRITE : READ;
        end
      end
      READ, WRITE: begin
        if (w_beat) begin
          if (r_beats == '0) w_state_nxt = IDLE;
          else               w_beats_nxt = r_beats - MEM_LEN_BITS'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic; every routed bus reads zero while unselected.
  always_comb begin
    bus.c0_req_ready   = 1'b0;
    bus.c1_req_ready   = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_opcode = 1'b0;
    bus.mem_req_len    = '0;
    bus.mem_req_addr   = '0;
    bus.mem_rd_ready   = 1'b0;
    bus.c0_rd_valid    = 1'b0;
    bus.c0_rd_bits     = '0;
    bus.c1_rd_valid    = 1'b0;
    bus.c1_rd_bits     = '0;
    bus.mem_wr_valid   = 1'b0;
    bus.mem_wr_bits    = '0;
    unique case (r_state)
      IDLE: begin
        if (w_grant) begin
          bus.c0_req_ready   = ~w_gnt_sel;
          bus.c1_req_ready   = w_gnt_sel;
          bus.mem_req_valid  = 1'b1;
          bus.mem_req_opcode = w_gnt_op;
          bus.mem_req_len    = w_gnt_len;
          bus.mem_req_addr   = w_gnt_addr;
        end
      end
      READ: begin
        bus.mem_rd_ready = w_own_rd_ready;
        if (r_owner) begin
          bus.c1_rd_valid = bus.mem_rd_valid;
          bus.c1_rd_bits  = bus.mem_rd_bits;
        end else begin
          bus.c0_rd_valid = bus.mem_rd_valid;
          bus.c0_rd_bits  = bus.mem_rd_bits;
        end
      end
      WRITE: begin
        bus.mem_wr_valid = w_own_wr_valid;
        bus.mem_wr_bits  = r_owner ? bus.c1_wr_bits : bus.c0_wr_bits;
      end
      default: ;
    endcase
    bus.busy  = (r_state != IDLE);
    bus.owner = r_owner;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter: a cycle-by-cycle vector table for
//   single read/write and contention, then hand-written sequences for
//   fairness, backpressure, maximum length and reset mid-transaction.
module tb_mem_arbiter;
  localparam int LB = 8;
  localparam int AB = 32;
  localparam int DB = 64;
  localparam logic [63:0] Z  = 64'h0;
  localparam logic [63:0] W0 = 64'h0000_0000_AAAA_5555;
  localparam logic [63:0] W1 = 64'h0000_0000_DEAD_BEEF;
  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  mem_arbiter_if #(.MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB)) bus ();

  mem_arbiter #(.MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  rv;
    logic [1:0]  op;
    logic [7:0]  len0;
    logic [7:0]  len1;
    logic        mrv;
    logic [63:0] mrb;
    logic [1:0]  rdy;
    logic [1:0]  wv;
    logic [1:0]  gnt;
    logic        mreq;
    logic        mop;
    logic [7:0]  mlen;
    logic        mrr;
    logic [1:0]  rve;
    logic [63:0] rb0;
    logic [63:0] rb1;
    logic        mwv;
    logic [63:0] mwb;
    logic        busy;
    logic        own;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(input int rst, input int rv, input int op, input int len0,
                             input int len1, input int mrv, input logic [63:0] mrb,
                             input int rdy, input int wv, input int gnt, input int mreq,
                             input int mop, input int mlen, input int mrr, input int rve,
                             input logic [63:0] rb0, input logic [63:0] rb1, input int mwv,
                             input logic [63:0] mwb, input int busy, input int own);
    vec_t v;
    v.rst = rst[0];   v.rv = rv[1:0];     v.op = op[1:0];
    v.len0 = len0[7:0]; v.len1 = len1[7:0];
    v.mrv = mrv[0];   v.mrb = mrb;        v.rdy = rdy[1:0];  v.wv = wv[1:0];
    v.gnt = gnt[1:0]; v.mreq = mreq[0];   v.mop = mop[0];    v.mlen = mlen[7:0];
    v.mrr = mrr[0];   v.rve = rve[1:0];   v.rb0 = rb0;       v.rb1 = rb1;
    v.mwv = mwv[0];   v.mwb = mwb;        v.busy = busy[0];  v.own = own[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0;
    bus.c0_req_valid = 1'b0; bus.c0_req_opcode = 1'b0; bus.c0_req_len = '0;
    bus.c1_req_valid = 1'b0; bus.c1_req_opcode = 1'b0; bus.c1_req_len = '0;
    bus.c0_req_addr = A0;    bus.c1_req_addr = A1;
    bus.c0_wr_valid = 1'b0;  bus.c0_wr_bits = W0;
    bus.c1_wr_valid = 1'b0;  bus.c1_wr_bits = W1;
    bus.c0_rd_ready = 1'b0;  bus.c1_rd_ready = 1'b0;
    bus.mem_rd_valid = 1'b0; bus.mem_rd_bits = '0;
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst;
    bus.c0_req_valid = v.rv[0]; bus.c1_req_valid = v.rv[1];
    bus.c0_req_opcode = v.op[0]; bus.c1_req_opcode = v.op[1];
    bus.c0_req_len = v.len0;    bus.c1_req_len = v.len1;
    bus.mem_rd_valid = v.mrv;   bus.mem_rd_bits = v.mrb;
    bus.c0_rd_ready = v.rdy[0]; bus.c1_rd_ready = v.rdy[1];
    bus.c0_wr_valid = v.wv[0];  bus.c1_wr_valid = v.wv[1];
  endtask

  task automatic check_vec(input int i, input vec_t v);
    string p;
    logic [31:0] exp_addr;
    p = $sformatf("v%0d", i);
    exp_addr = v.mreq ? (v.gnt[1] ? A1 : A0) : 32'h0;
    chk({p, ".c0_req_ready"},   64'(bus.c0_req_ready),   64'(v.gnt[0]));
    chk({p, ".c1_req_ready"},   64'(bus.c1_req_ready),   64'(v.gnt[1]));
    chk({p, ".mem_req_valid"},  64'(bus.mem_req_valid),  64'(v.mreq));
    chk({p, ".mem_req_opcode"}, 64'(bus.mem_req_opcode), 64'(v.mop));
    chk({p, ".mem_req_len"},    64'(bus.mem_req_len),    64'(v.mlen));
    chk({p, ".mem_req_addr"},   64'(bus.mem_req_addr),   64'(exp_addr));
    chk({p, ".mem_rd_ready"},   64'(bus.mem_rd_ready),   64'(v.mrr));
    chk({p, ".c0_rd_valid"},    64'(bus.c0_rd_valid),    64'(v.rve[0]));
    chk({p, ".c1_rd_valid"},    64'(bus.c1_rd_valid),    64'(v.rve[1]));
    chk({p, ".c0_rd_bits"},     bus.c0_rd_bits,          v.rb0);
    chk({p, ".c1_rd_bits"},     bus.c1_rd_bits,          v.rb1);
    chk({p, ".mem_wr_valid"},   64'(bus.mem_wr_valid),   64'(v.mwv));
    chk({p, ".mem_wr_bits"},    bus.mem_wr_bits,         v.mwb);
    chk({p, ".busy"},           64'(bus.busy),           64'(v.busy));
    chk({p, ".owner"},          64'(bus.owner),          64'(v.own));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;

    // rst,rv,op,l0,l1, mrv,mrb,rdy,wv | gnt,mreq,mop,mlen,mrr,rve,rb0,rb1,mwv,mwb,busy,own
    tbl.push_back(V(1,0,0,0,0, 0,Z,0,0,           0,0,0,0,0,0,Z,Z,0,Z,0,0));
    tbl.push_back(V(0,0,0,0,0, 0,Z,0,0,           0,0,0,0,0,0,Z,Z,0,Z,0,0));
    // single read, client 0, len 3, beats with stalls
    tbl.push_back(V(0,1,0,3,0, 0,Z,1,0,           1,1,0,3,0,0,Z,Z,0,Z,0,0));
    tbl.push_back(V(0,0,0,0,0, 0,Z,1,0,           0,0,0,0,1,0,Z,Z,0,Z,1,0));
    tbl.push_back(V(0,0,0,0,0, 1,64'h11,1,0,      0,0,0,0,1,1,64'h11,Z,0,Z,1,0));
    tbl.push_back(V(0,0,0,0,0, 0,Z,1,0,           0,0,0,0,1,0,Z,Z,0,Z,1,0));
    tbl.push_back(V(0,0,0,0,0, 1,64'h22,1,0,      0,0,0,0,1,1,64'h22,Z,0,Z,1,0));
    tbl.push_back(V(0,0,0,0,0, 1,64'h33,1,0,      0,0,0,0,1,1,64'h33,Z,0,Z,1,0));
    tbl.push_back(V(0,0,0,0,0, 0,Z,1,0,           0,0,0,0,1,0,Z,Z,0,Z,1,0));
    tbl.push_back(V(0,0,0,0,0, 1,64'h44,1,0,      0,0,0,0,1,1,64'h44,Z,0,Z,1,0));
    tbl.push_back(V(0,0,0,0,0, 1,64'h55,1,0,      0,0,0,0,0,0,Z,Z,0,Z,0,0));
    // single write, client 1, len 0; client 0 write beat must be ignored
    tbl.push_back(V(0,2,2,0,0, 0,Z,0,0,           2,1,1,0,0,0,Z,Z,0,Z,0,0));
    tbl.push_back(V(0,0,0,0,0, 0,Z,0,3,           0,0,0,0,0,0,Z,Z,1,W1,1,1));
    tbl.push_back(V(0,0,0,0,0, 0,Z,0,0,           0,0,0,0,0,0,Z,Z,0,Z,0,1));
    // reset, then contention: c0 read len 1 vs c1 write len 1
    tbl.push_back(V(1,0,0,0,0, 0,Z,0,0,           0,0,0,0,0,0,Z,Z,0,Z,0,1));
    tbl.push_back(V(0,3,2,1,1, 0,Z,0,0,           1,1,0,1,0,0,Z,Z,0,Z,0,0));
    tbl.push_back(V(0,2,2,0,1, 1,64'hA1,1,0,      0,0,0,0,1,1,64'hA1,Z,0,Z,1,0));
    tbl.push_back(V(0,2,2,0,1, 1,64'hA2,1,0,      0,0,0,0,1,1,64'hA2,Z,0,Z,1,0));
    tbl.push_back(V(0,2,2,0,1, 0,Z,0,0,           2,1,1,1,0,0,Z,Z,0,Z,0,0));
    tbl.push_back(V(0,0,0,0,0, 0,Z,0,0,           0,0,0,0,0,0,Z,Z,0,W1,1,1));
    tbl.push_back(V(0,0,0,0,0, 0,Z,0,2,           0,0,0,0,0,0,Z,Z,1,W1,1,1));
    tbl.push_back(V(0,0,0,0,0, 0,Z,0,2,           0,0,0,0,0,0,Z,Z,1,W1,1,1));
    tbl.push_back(V(0,0,0,0,0, 0,Z,0,0,           0,0,0,0,0,0,Z,Z,0,Z,0,1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clock);
      check_vec(i, tbl[i]);
      step();
    end

    // Fairness: both request len-0 reads continuously; grants alternate 0,1,...
    idle_inputs();
    bus.c0_req_valid = 1'b1; bus.c1_req_valid = 1'b1;
    bus.c0_rd_ready = 1'b1;  bus.c1_rd_ready = 1'b1;
    bus.mem_rd_valid = 1'b1; bus.mem_rd_bits = 64'h77;
    for (int t = 0; t < 12; t++) begin
      int k;
      k = (t / 2) % 2;
      @(negedge clock);
      if (t % 2 == 0) begin
        chk($sformatf("fair%0d.c0_req_ready", t), 64'(bus.c0_req_ready), 64'(k == 0));
        chk($sformatf("fair%0d.c1_req_ready", t), 64'(bus.c1_req_ready), 64'(k == 1));
      end else begin
        chk($sformatf("fair%0d.owner", t), 64'(bus.owner), 64'(k));
        chk($sformatf("fair%0d.rd_valid", t),
            64'(k == 1 ? bus.c1_rd_valid : bus.c0_rd_valid), 64'(1));
      end
      step();
    end

    // Backpressure: c0 read len 2, rd_ready toggles 1,0,1,0,...
    idle_inputs();
    bus.c0_req_valid = 1'b1; bus.c0_req_len = 8'd2;
    @(negedge clock);
    chk("bp.grant", 64'(bus.c0_req_ready), 64'(1));
    chk("bp.len",   64'(bus.mem_req_len),  64'(2));
    step();
    bus.c0_req_valid = 1'b0;
    bus.mem_rd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic act;
      act = (i <= 4);
      bus.c0_rd_ready = (i % 2 == 0);
      bus.mem_rd_bits = 64'(8'hB0 + i);
      @(negedge clock);
      chk($sformatf("bp%0d.mem_rd_ready", i), 64'(bus.mem_rd_ready), 64'(act && (i % 2 == 0)));
      chk($sformatf("bp%0d.c0_rd_valid", i),  64'(bus.c0_rd_valid),  64'(act));
      chk($sformatf("bp%0d.c0_rd_bits", i),   bus.c0_rd_bits,        act ? 64'(8'hB0 + i) : Z);
      chk($sformatf("bp%0d.busy", i),         64'(bus.busy),         64'(act));
      step();
    end

    // Maximum length: c1 write len 255 takes exactly 256 beats
    idle_inputs();
    bus.c1_req_valid = 1'b1; bus.c1_req_opcode = 1'b1; bus.c1_req_len = 8'd255;
    @(negedge clock);
    chk("max.grant",  64'(bus.c1_req_ready),   64'(1));
    chk("max.opcode", 64'(bus.mem_req_opcode), 64'(1));
    chk("max.len",    64'(bus.mem_req_len),    64'(255));
    step();
    bus.c1_req_valid = 1'b0;
    bus.c1_wr_valid = 1'b1;
    for (int i = 0; i <= 256; i++) begin
      @(negedge clock);
      chk($sformatf("max%0d.busy", i),         64'(bus.busy),         64'(i < 256));
      chk($sformatf("max%0d.mem_wr_valid", i), 64'(bus.mem_wr_valid), 64'(i < 256));
      step();
    end

    // Reset after beat 2 of a len-7 write by c0
    idle_inputs();
    bus.c0_req_valid = 1'b1; bus.c0_req_opcode = 1'b1; bus.c0_req_len = 8'd7;
    @(negedge clock);
    chk("rst.grant", 64'(bus.c0_req_ready), 64'(1));
    step();
    bus.c0_req_valid = 1'b0; bus.c0_wr_valid = 1'b1;
    @(negedge clock);
    chk("rst.beat1", 64'(bus.mem_wr_valid), 64'(1));
    step();
    @(negedge clock);
    chk("rst.beat2", 64'(bus.mem_wr_valid), 64'(1));
    step();
    reset = 1'b1; bus.c1_req_valid = 1'b1;
    @(negedge clock);
    chk("rst.busy_in_reset", 64'(bus.busy), 64'(1));
    step();
    reset = 1'b0;
    bus.c0_req_valid = 1'b1; bus.c0_req_len = 8'd0;
    bus.c1_req_opcode = 1'b1; bus.c1_req_len = 8'd0;
    @(negedge clock);
    chk("rst.busy_after",   64'(bus.busy),         64'(0));
    chk("rst.mem_wr_valid", 64'(bus.mem_wr_valid), 64'(0));
    chk("rst.prio_c0",      64'(bus.c0_req_ready), 64'(1));
    chk("rst.prio_c1",      64'(bus.c1_req_ready), 64'(0));
    step();
    bus.c0_req_valid = 1'b0;
    @(negedge clock);
    chk("rst.c0_beat_valid", 64'(bus.mem_wr_valid), 64'(1));
    chk("rst.c0_beat_bits",  bus.mem_wr_bits,       W0);
    step();
    bus.c0_wr_valid = 1'b0;
    @(negedge clock);
    chk("rst.c1_grant",  64'(bus.c1_req_ready),   64'(1));
    chk("rst.c1_opcode", 64'(bus.mem_req_opcode), 64'(1));
    chk("rst.c1_addr",   64'(bus.mem_req_addr),   64'(A1));
    step();
    bus.c1_req_valid = 1'b0; bus.c1_wr_valid = 1'b1;
    @(negedge clock);
    chk("rst.c1_beat_valid", 64'(bus.mem_wr_valid), 64'(1));
    chk("rst.c1_beat_bits",  bus.mem_wr_bits,       W1);
    step();
    bus.c1_wr_valid = 1'b0;
    // No grant while reset is asserted in IDLE
    reset = 1'b1; bus.c0_req_valid = 1'b1;
    @(negedge clock);
    chk("rst.no_grant_ready", 64'(bus.c0_req_ready),  64'(0));
    chk("rst.no_grant_mreq",  64'(bus.mem_req_valid), 64'(0));
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("rst.grant_after_release", 64'(bus.c0_req_ready), 64'(1));
    step();
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
